uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART transmitter between two byte requesters (req0, req1) with round-robin arbitration.
//  Sequences each frame: grant, launch, wait for tx_done, inter-frame gap.
//  Owns the baud select BC: cfg_bc reaches tx_bc only while no frame is in flight.
//  link_reset (the receiver's Mreset) aborts scheduling at once.
// PARAMETERS
//  GAP_CYCLES      2     idle clocks after tx_done before next grant; 0 = go straight to IDLE
//  TIMEOUT_CYCLES  8192  watchdog limit in WAIT_DONE; > 434*11 clocks (slowest frame at 50 MHz)
// PORTS
//  clk          in   1  50 MHz system clock
//  reset        in   1  asynchronous, active-low reset
//  req0/req1    in   1  byte request; held high until matching ack
//  data0/data1  in   8  byte per requester; stable while its req is high
//  ack0/ack1    out  1  1-cycle pulse: byte accepted, handed to transmitter
//  cfg_bc       in   3  requested baud select (000=434, 001=217, 010=109, 011=72, 100=36 clk/bit)
//  tx_bc        out  3  baud select applied to transmitter
//  tx_start     out  1  1-cycle launch strobe to transmitter
//  tx_data      out  8  registered byte to transmitter, held until next launch
//  tx_busy      in   1  transmitter busy
//  tx_done      in   1  1-cycle pulse: stop bit complete
//  link_reset   in   1  active-high abort from receiver (Mreset)
//  grant_id     out  1  requester of current/last frame
//  timeout_err  out  1  1-cycle pulse on watchdog expiry (tied 0 if feature off)
// BEHAVIOUR
//  - Reset (reset=0): FSM=IDLE. Outputs ack*, tx_start, tx_data, tx_bc, grant_id, timeout_err = 0.
//    last_grant=1, so requester 0 wins the first tie.
//  - States: IDLE -> LAUNCH -> WAIT_DONE -> GAP -> IDLE.
//  - IDLE: tx_bc <= cfg_bc every cycle. If (req0|req1) && !tx_busy, go to LAUNCH and capture winner:
//    - Both requesting: winner = !last_grant.
//    - One requesting: winner = that requester.
//  - LAUNCH (1 cycle): tx_start=1, tx_data=winner byte, ack<winner>=1, grant_id=last_grant=winner.
//    Latency: req sampled in cycle N -> tx_start/ack in cycle N+1. Next state WAIT_DONE.
//  - WAIT_DONE: tx_bc frozen. On tx_done go to GAP (or IDLE if GAP_CYCLES=0).
//    A tx_done arriving in the LAUNCH cycle is ignored.
//  - GAP: count GAP_CYCLES clocks, then IDLE. Requests are not sampled during GAP.
//  - Fairness: with both req held, grants alternate 0,1,0,1...
//    A lone requester may be granted back to back.
//  - link_reset=1 (any state, sync): next state IDLE; tx_start/ack forced 0 that cycle.
//    FSM stays in IDLE while link_reset is held; counters clear. Wins over a simultaneous tx_done.
//    A frame already acked is lost (not re-requested).
//  - tx_data and grant_id hold their value outside LAUNCH.
//  - Gap counter width is $clog2(GAP_CYCLES+1); it never wraps.
//  - Async reset mid-frame: immediate return to reset values; transmitter resets independently.
// CONFIGURATION
//  UART_TX_SCHED_TIMEOUT_EN defined:
//    - 13-bit+ watchdog counts in WAIT_DONE.
//    - At TIMEOUT_CYCLES without tx_done: timeout_err pulses 1 cycle, FSM -> IDLE (no GAP).
//  Not defined: no counter; WAIT_DONE waits indefinitely; timeout_err constant 0.
// TESTING
//  1. req0=1, data0=8'hA5, tx_busy=0 -> next cycle tx_start=1, ack0=1, tx_data=A5, grant_id=0;
//     tx_done -> 2 GAP clocks -> IDLE.
//  2. req0=req1=1 held, data0=8'h11, data1=8'h22 -> launches 11,22,11,22;
//     ack0/ack1 alternate; each launch exactly one tx_start.
//  3. cfg_bc 000->100 in WAIT_DONE -> tx_bc stays 000 until first IDLE cycle after GAP, then 100.
//  4. link_reset=1 in WAIT_DONE, same cycle as tx_done -> IDLE next cycle, no GAP;
//     req1 pending launches on the first cycle after link_reset drops.
//  5. tx_busy=1 in IDLE with req0=1 -> no tx_start/ack; tx_busy->0 -> launch next cycle.
//  6. TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no tx_done -> timeout_err pulse 16 clocks after LAUNCH,
//     FSM IDLE; undefined -> still WAIT_DONE, timeout_err=0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between two byte requesters.
// Optional WAIT_DONE watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    input  logic [2:0] cfg_bc,
    output logic [2:0] tx_bc,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    input  logic       link_reset,
    output logic       grant_id,
    output logic       timeout_err
);
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_e;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_q, grant_d;
    logic [7:0]    data_q, data_d;
    logic [2:0]    bc_q, bc_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          winner;
    logic          timeout;

    // On a tie the requester that did not win last time goes first.
    assign winner = (req0 && req1) ? ~last_grant_q : req1;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 13) ? $clog2(TIMEOUT_CYCLES + 1) : 13;
    logic [TW-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = '0;
        if (state_q == S_WAIT_DONE && !link_reset) begin
            wd_d = wd_q + 1'b1;
        end
    end

    assign timeout = (state_q == S_WAIT_DONE) && (wd_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        data_d       = data_q;
        bc_d         = bc_q;
        gap_d        = '0;
        tx_start     = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        timeout_err  = 1'b0;
        if (link_reset) begin
            state_d = S_IDLE;
            if (state_q == S_IDLE) begin
                bc_d = cfg_bc;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    bc_d = cfg_bc;
                    if ((req0 || req1) && !tx_busy) begin
                        state_d      = S_LAUNCH;
                        grant_d      = winner;
                        last_grant_d = winner;
                        data_d       = winner ? data1 : data0;
                    end
                end
                S_LAUNCH: begin
                    tx_start = 1'b1;
                    ack0     = ~grant_q;
                    ack1     = grant_q;
                    state_d  = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // tx_done takes priority over a watchdog expiry in the same cycle.
                    if (tx_done) begin
                        state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end else if (timeout) begin
                        timeout_err = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            data_q       <= '0;
            bc_q         <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            data_q       <= data_d;
            bc_q         <= bc_d;
            gap_q        <= gap_d;
        end
    end

    assign tx_data  = data_q;
    assign tx_bc    = bc_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: directed scenarios plus randomized requesters.
// Timeout expectations follow UART_TX_SCHED_TIMEOUT_EN when defined.
module tb_uart_tx_scheduler;
    localparam int unsigned GAP = 2;
    localparam int unsigned TMO = 16;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       ack0, ack1;
    logic [2:0] cfg_bc = '0;
    logic [2:0] tx_bc;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy, tx_done;
    logic       link_reset = 1'b0;
    logic       grant_id, timeout_err;

    logic busy_a = 1'b0, done_a = 1'b0, busy_m = 1'b0, done_m = 1'b0;
    bit   auto_tx = 1'b0;
    assign tx_busy = busy_a | busy_m;
    assign tx_done = done_a | done_m;

    uart_tx_scheduler #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .data0      (data0),
        .data1      (data1),
        .ack0       (ack0),
        .ack1       (ack1),
        .cfg_bc     (cfg_bc),
        .tx_bc      (tx_bc),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .link_reset (link_reset),
        .grant_id   (grant_id),
        .timeout_err(timeout_err)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Reference model state: expected bytes per requester, round-robin pointer,
    // and which cycles a launch is legal in / tx_bc must stay frozen.
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    bit          m_last = 1'b1;
    bit          in_flight = 1'b0;
    int          bc_hold = 0;
    int          wcnt = 0;
    logic [2:0]  bc_launch = '0;
    logic        p_req0 = 1'b0, p_req1 = 1'b0, p_busy = 1'b0, p_lr = 1'b0;
    logic [2:0]  p_cfg = '0;
    bit          m_w;
    bit          exp_to;
    logic [7:0]  m_b;

    always @(negedge clk) begin
        exp_to = 1'b0;
        if (reset) begin
            if (tx_start) begin
                if (in_flight || bc_hold > 0 || p_busy || p_lr || link_reset || !(p_req0 || p_req1)) begin
                    flag("spurious_start");
                end else begin
                    m_w = (p_req0 && p_req1) ? ~m_last : p_req1;
                    chk("ack0", 32'(ack0), 32'(!m_w));
                    chk("ack1", 32'(ack1), 32'(m_w));
                    chk("grant_id", 32'(grant_id), 32'(m_w));
                    chk("launch_bc", 32'(tx_bc), 32'(p_cfg));
                    if (m_w == 1'b0 && q0.size() > 0) begin
                        m_b = q0.pop_front();
                        chk("tx_data0", 32'(tx_data), 32'(m_b));
                    end else if (m_w == 1'b1 && q1.size() > 0) begin
                        m_b = q1.pop_front();
                        chk("tx_data1", 32'(tx_data), 32'(m_b));
                    end else begin
                        flag("ack_without_queued_byte");
                    end
                    m_last = m_w;
                end
                in_flight = 1'b1;
                bc_launch = p_cfg;
                wcnt = 0;
            end else if (ack0 || ack1) begin
                flag("ack_without_start");
            end else if (in_flight) begin
                chk("bc_frozen", 32'(tx_bc), 32'(bc_launch));
                wcnt++;
                exp_to = TO_EN && (wcnt == TMO) && !tx_done && !link_reset;
                if (link_reset) begin
                    in_flight = 1'b0;
                    bc_hold = 1;
                end else if (tx_done) begin
                    in_flight = 1'b0;
                    bc_hold = GAP + 1;
                end else if (exp_to) begin
                    in_flight = 1'b0;
                    bc_hold = 1;
                end
            end else if (bc_hold > 0) begin
                chk("bc_hold", 32'(tx_bc), 32'(bc_launch));
                bc_hold--;
            end
            chk("timeout_err", 32'(timeout_err), 32'(exp_to));
        end
        p_req0 = req0;
        p_req1 = req1;
        p_busy = tx_busy;
        p_lr   = link_reset;
        p_cfg  = cfg_bc;
    end

    // Behavioural transmitter: busy after launch, tx_done after a random frame length.
    int unsigned dur;
    initial begin
        forever begin
            @(negedge clk);
            if (auto_tx && tx_start) begin
                dur = $urandom_range(2, 10);
                @(posedge clk);
                #1 busy_a = 1'b1;
                repeat (dur) @(posedge clk);
                #1 busy_a = 1'b0;
                done_a = 1'b1;
                @(posedge clk);
                #1 done_a = 1'b0;
            end
        end
    end

    task automatic requester(input int r, input int n, input bit rnd);
        logic [7:0]  b;
        int unsigned k;
        bit          got;
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : ((r == 1) ? 8'h22 : 8'h11);
            if (r == 0) begin
                data0 = b; req0 = 1'b1; q0.push_back(b);
            end else begin
                data1 = b; req1 = 1'b1; q1.push_back(b);
            end
            got = 1'b0;
            for (int c = 0; c < 2000 && !got; c++) begin
                @(negedge clk);
                if ((r == 0) ? ack0 : ack1) got = 1'b1;
            end
            if (!got) flag("wait_ack");
            cyc();
            if (rnd) begin
                k = $urandom_range(0, 3);
                if (k > 0) begin
                    if (r == 0) req0 = 1'b0; else req1 = 1'b0;
                    repeat (k) cyc();
                end
            end
        end
        if (r == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic manual_finish();
        busy_m = 1'b1;
        cyc();
        cyc();
        busy_m = 1'b0;
        done_m = 1'b1;
        cyc();
        done_m = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation did not finish in time");
        $fatal(1);
    end

    bit rand_done;
    int to_seen;
    bit got1;

    initial begin
        // reset values
        repeat (3) smp();
        chk("rst_ack0", 32'(ack0), 0);
        chk("rst_ack1", 32'(ack1), 0);
        chk("rst_start", 32'(tx_start), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_bc", 32'(tx_bc), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        cyc();
        reset = 1'b1;
        repeat (2) cyc();

        // single request latency, then gap length before the next launch
        req0 = 1'b1; data0 = 8'hA5; q0.push_back(8'hA5);
        smp(); chk("t1_wait", 32'(tx_start), 0);
        cyc();
        smp(); chk("t1_launch", 32'(tx_start), 1);
        chk("t1_data", 32'(tx_data), 32'h A5);
        chk("t1_grant", 32'(grant_id), 0);
        cyc();
        req0 = 1'b0; busy_m = 1'b1;
        cyc(); cyc();
        busy_m = 1'b0; done_m = 1'b1;
        cyc();
        done_m = 1'b0; req0 = 1'b1; data0 = 8'h5A; q0.push_back(8'h5A);
        for (int i = 0; i < 3; i++) begin
            smp(); chk("t1_gap", 32'(tx_start), 0);
            cyc();
        end
        smp(); chk("t1_relaunch", 32'(tx_start), 1);

        // baud select frozen while a frame is in flight
        cyc();
        req0 = 1'b0; busy_m = 1'b1; cfg_bc = 3'b100;
        cyc(); cyc();
        busy_m = 1'b0; done_m = 1'b1;
        cyc();
        done_m = 1'b0;
        smp(); chk("t3_bc_gap", 32'(tx_bc), 0);
        cyc(); cyc();
        smp(); chk("t3_bc_idle", 32'(tx_bc), 0);
        cyc();
        smp(); chk("t3_bc_new", 32'(tx_bc), 32'h4);
        repeat (2) cyc();

        // tx_busy holds off a pending request
        busy_m = 1'b1;
        cyc();
        req0 = 1'b1; data0 = 8'hC3; q0.push_back(8'hC3);
        repeat (4) begin
            smp(); chk("t5_busy", 32'(tx_start), 0);
            cyc();
        end
        busy_m = 1'b0;
        smp(); chk("t5_release", 32'(tx_start), 0);
        cyc();
        smp(); chk("t5_launch", 32'(tx_start), 1);
        cyc();
        req0 = 1'b0;
        manual_finish();

        // link_reset together with tx_done skips the gap
        req0 = 1'b1; data0 = 8'h77; q0.push_back(8'h77);
        cyc();
        smp(); chk("t4_launch0", 32'(tx_start), 1);
        cyc();
        req0 = 1'b0; req1 = 1'b1; data1 = 8'h99; q1.push_back(8'h99); busy_m = 1'b1;
        cyc(); cyc();
        busy_m = 1'b0; done_m = 1'b1; link_reset = 1'b1;
        cyc();
        done_m = 1'b0; link_reset = 1'b0;
        smp(); chk("t4_idle", 32'(tx_start), 0);
        cyc();
        smp(); chk("t4_launch1", 32'(tx_start), 1);
        chk("t4_grant1", 32'(grant_id), 1);
        cyc();
        req1 = 1'b0;
        manual_finish();

        // both held: strict alternation
        auto_tx = 1'b1;
        fork
            requester(0, 4, 1'b0);
            requester(1, 4, 1'b0);
        join
        repeat (20) cyc();

        // randomized traffic with cfg_bc changes
        rand_done = 1'b0;
        fork
            begin
                fork
                    requester(0, 20, 1'b1);
                    requester(1, 20, 1'b1);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    cyc();
                    if ($urandom_range(0, 7) == 0) cfg_bc = 3'($urandom_range(0, 4));
                end
            end
        join
        repeat (20) cyc();

        // no tx_done: watchdog behaviour
        auto_tx = 1'b0;
        req0 = 1'b1; data0 = 8'h3C; q0.push_back(8'h3C);
        cyc();
        smp(); chk("t6_launch", 32'(tx_start), 1);
        cyc();
        req0 = 1'b0;
        to_seen = 0;
        for (int c = 1; c <= 30; c++) begin
            smp();
            if (timeout_err && to_seen == 0) to_seen = c;
            cyc();
        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
        chk("t6_timeout_at", 32'(to_seen), 32'(TMO));
`else
        chk("t6_no_timeout", 32'(to_seen), 0);
        req1 = 1'b1; data1 = 8'hE7; q1.push_back(8'hE7);
        repeat (5) cyc();
        auto_tx = 1'b1;
        done_m = 1'b1;
        cyc();
        done_m = 1'b0;
        got1 = 1'b0;
        for (int c = 0; c < 20 && !got1; c++) begin
            smp();
            if (ack1) got1 = 1'b1;
        end
        if (!got1) flag("t6_post_wait_ack");
        cyc();
        req1 = 1'b0;
`endif
        repeat (20) cyc();
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
